// File: rtl/reminder_pkg.sv
// Shared types and helpers for the water-reminder countdown engine.
// Optional snooze support is selected with the REMINDER_SNOOZE_EN macro
// (see reminder_timer.sv); nothing here depends on it.
package reminder_pkg;

   typedef enum logic [1:0] {OFF, RUN, PAUSE, ALERT} state_t;

   localparam logic [1:0] MODE_OFF   = 2'b00;
   localparam logic [1:0] MODE_RUN   = 2'b01;
   localparam logic [1:0] MODE_PAUSE = 2'b10;
   localparam logic [1:0] MODE_TEST  = 2'b11;

   typedef logic [3:0] bcd_t;

   typedef struct packed {
      bcd_t tens;
      bcd_t ones;
   } bcd2_t;

   // Snooze reload length in minutes
   localparam int unsigned SNOOZE_MIN = 5;

   // Interval in minutes = step * (sel + 1), returned as two BCD digits
   function automatic bcd2_t interval_to_bcd(input logic [3:0] sel, input int unsigned step);
      int unsigned m;
      bcd2_t       r;
      m      = step * (32'(sel) + 32'd1);
      r.tens = 4'(m / 32'd10);
      r.ones = 4'(m % 32'd10);
      return r;
   endfunction

endpackage

// File: rtl/reminder_timer_tick_divider.sv
// Dual-rate seconds divider: counts 0..DIV-1 and pulses sec_tick on the
// wrap cycle. DIV is TICK_DIV normally, TEST_DIV when fast is set.
// clear forces the count to 0, hold freezes it.
module tick_divider #(
   parameter int unsigned TICK_DIV = 50_000_000,
   parameter int unsigned TEST_DIV = 50_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic fast,
   input  logic hold,
   input  logic clear,
   output logic sec_tick
);

   localparam int unsigned MAX_DIV = (TICK_DIV > TEST_DIV) ? TICK_DIV : TEST_DIV;
   localparam int          CNT_W   = $clog2(MAX_DIV + 1);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] lim;
   logic             wrap;

   // A count already past the new limit (rate switched mid-second) wraps at once
   assign lim      = fast ? CNT_W'(TEST_DIV - 1) : CNT_W'(TICK_DIV - 1);
   assign wrap     = !clear && !hold && (cnt >= lim);
   assign sec_tick = wrap;

   // Counter: clear wins over hold, hold freezes, otherwise count and wrap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (!hold) begin
         cnt <= wrap ? '0 : cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/reminder_timer.sv
// Water-reminder countdown engine. Drives BCD mm:ss remaining time, the alert
// flag and a saturating BCD drink counter to the VGA display stage.
// Build option: define REMINDER_SNOOZE_EN to add the snooze input, which in
// ALERT reloads SNOOZE_MIN minutes without counting a drink.
module reminder_timer
   import reminder_pkg::*;
#(
   parameter int unsigned TICK_DIV = 50_000_000,
   parameter int unsigned TEST_DIV = 50_000,
   parameter int unsigned STEP_MIN = 5
) (
   input  logic       CLOCK_50,
   input  logic       reset_n,
   input  logic [3:0] interval_sel,
   input  logic [1:0] mode,
   input  logic       ack,
`ifdef REMINDER_SNOOZE_EN
   input  logic       snooze,
`endif
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       alert,
   output logic [3:0] drink_tens,
   output logic [3:0] drink_ones,
   output logic       sec_tick
);

   // Decrement a BCD mm:ss value by one second, borrowing through the digits
   function automatic logic [15:0] bcd_time_dec(input logic [15:0] t);
      logic [15:0] r;
      r = t;
      if (t[3:0] != 4'd0) begin
         r[3:0] = t[3:0] - 4'd1;
      end else begin
         r[3:0] = 4'd9;
         if (t[7:4] != 4'd0) begin
            r[7:4] = t[7:4] - 4'd1;
         end else begin
            r[7:4] = 4'd5;
            if (t[11:8] != 4'd0) begin
               r[11:8] = t[11:8] - 4'd1;
            end else begin
               r[11:8]  = 4'd9;
               r[15:12] = t[15:12] - 4'd1;
            end
         end
      end
      return r;
   endfunction

   // Two-digit BCD increment that sticks at 99
   function automatic bcd2_t drink_inc_sat(input bcd2_t d);
      bcd2_t r;
      r = d;
      if (d == 8'h99) begin
         r = d;
      end else if (d.ones == 4'd9) begin
         r.ones = 4'd0;
         r.tens = d.tens + 4'd1;
      end else begin
         r.ones = d.ones + 4'd1;
      end
      return r;
   endfunction

   localparam logic [15:0] SNOOZE_TIME = {4'(SNOOZE_MIN / 10), 4'(SNOOZE_MIN % 10), 8'h00};

   state_t      state;
   logic [15:0] time_q;
   logic        alert_q;
   bcd2_t       drinks;
   bcd2_t       ivl;
   logic        ack_p0, ack_p1, ack_p2;
   logic        ack_pulse;
   logic        run_en;
   logic        div_clear;
   logic        tick;

   assign ivl = interval_to_bcd(interval_sel, STEP_MIN);

   // ack synchronizer and rising-edge detect; pulse lands 2 cycles after ack rises
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         ack_p0 <= 1'b0;
         ack_p1 <= 1'b0;
         ack_p2 <= 1'b0;
      end else begin
         ack_p0 <= ack;
         ack_p1 <= ack_p0;
         ack_p2 <= ack_p1;
      end
   end

   assign ack_pulse = ack_p1 & ~ack_p2;

`ifdef REMINDER_SNOOZE_EN
   logic snz_p0, snz_p1, snz_p2;
   logic snz_pulse;

   // snooze synchronizer and rising-edge detect, same timing as ack
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         snz_p0 <= 1'b0;
         snz_p1 <= 1'b0;
         snz_p2 <= 1'b0;
      end else begin
         snz_p0 <= snooze;
         snz_p1 <= snz_p0;
         snz_p2 <= snz_p1;
      end
   end

   assign snz_pulse = snz_p1 & ~snz_p2;
`endif

   // Divider counts only in RUN; a mode-00 request in RUN freezes it for the exit cycle
   assign run_en    = (state == RUN) && (mode != MODE_OFF);
   assign div_clear = (state == OFF) || (state == ALERT);

   tick_divider #(
      .TICK_DIV (TICK_DIV),
      .TEST_DIV (TEST_DIV)
   ) u_div (
      .clk      (CLOCK_50),
      .rst_n    (reset_n),
      .fast     (mode == MODE_TEST),
      .hold     (!run_en),
      .clear    (div_clear),
      .sec_tick (tick)
   );

   // Main FSM: countdown, alert, acknowledge and drink counting
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state   <= OFF;
         time_q  <= 16'h0000;
         alert_q <= 1'b0;
         drinks  <= '0;
      end else begin
         case (state)
            OFF: begin
               time_q  <= {ivl, 8'h00};
               alert_q <= 1'b0;
               if (mode == MODE_RUN || mode == MODE_TEST) state <= RUN;
            end
            RUN: begin
               if (mode == MODE_OFF) begin
                  state <= OFF;
               end else begin
                  if (tick) time_q <= bcd_time_dec(time_q);
                  if (tick && time_q == 16'h0001) begin
                     state   <= ALERT;
                     alert_q <= 1'b1;
                  end else if (mode == MODE_PAUSE) begin
                     state <= PAUSE;
                  end
               end
            end
            PAUSE: begin
               if (mode == MODE_OFF) state <= OFF;
               else if (mode == MODE_RUN || mode == MODE_TEST) state <= RUN;
            end
            ALERT: begin
               if (mode == MODE_OFF) begin
                  state   <= OFF;
                  alert_q <= 1'b0;
               end else if (ack_pulse) begin
                  drinks  <= drink_inc_sat(drinks);
                  time_q  <= {ivl, 8'h00};
                  alert_q <= 1'b0;
                  state   <= RUN;
`ifdef REMINDER_SNOOZE_EN
               end else if (snz_pulse) begin
                  time_q  <= SNOOZE_TIME;
                  alert_q <= 1'b0;
                  state   <= RUN;
`endif
               end
            end
            default: state <= OFF;
         endcase
      end
   end

   // OFF shows the live interval so switch changes (and reset) appear immediately
   assign {min_tens, min_ones, sec_tens, sec_ones} = (state == OFF) ? {ivl, 8'h00} : time_q;
   assign alert      = alert_q;
   assign drink_tens = drinks.tens;
   assign drink_ones = drinks.ones;
   assign sec_tick   = tick;

endmodule

// File: tb/tb_reminder_timer.sv
// Directed bench for reminder_timer with TICK_DIV=4, TEST_DIV=2, STEP_MIN=5.
module tb_reminder_timer;

   logic       CLOCK_50;
   logic       reset_n;
   logic [3:0] interval_sel;
   logic [1:0] mode;
   logic       ack;
   logic       snooze;
   logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
   logic       alert;
   logic [3:0] drink_tens, drink_ones;
   logic       sec_tick;

   logic [15:0] tm;
   logic [7:0]  dr;
   assign tm = {min_tens, min_ones, sec_tens, sec_ones};
   assign dr = {drink_tens, drink_ones};

   int checks = 0;
   int passes = 0;

   reminder_timer #(
      .TICK_DIV (4),
      .TEST_DIV (2),
      .STEP_MIN (5)
   ) dut (
      .CLOCK_50     (CLOCK_50),
      .reset_n      (reset_n),
      .interval_sel (interval_sel),
      .mode         (mode),
      .ack          (ack),
`ifdef REMINDER_SNOOZE_EN
      .snooze       (snooze),
`endif
      .min_tens     (min_tens),
      .min_ones     (min_ones),
      .sec_tens     (sec_tens),
      .sec_ones     (sec_ones),
      .alert        (alert),
      .drink_tens   (drink_tens),
      .drink_ones   (drink_ones),
      .sec_tick     (sec_tick)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic step(input int n);
      repeat (n) @(negedge CLOCK_50);
   endtask

   task automatic wait_alert(input int bound, output bit ok);
      int n;
      n = 0;
      while (alert !== 1'b1 && n < bound) begin
         step(1);
         n++;
      end
      ok = (alert === 1'b1);
   endtask

   task automatic test_reset();
      reset_n = 1'b0; interval_sel = 4'd0; mode = 2'b00; ack = 1'b0; snooze = 1'b0;
      step(3);
      checks++; if (tm !== 16'h0500) $display("FAIL reset_time got %h want 0500", tm); else passes++;
      checks++; if (alert !== 1'b0) $display("FAIL reset_alert got %b want 0", alert); else passes++;
      checks++; if (dr !== 8'h00) $display("FAIL reset_drinks got %h want 00", dr); else passes++;
      checks++; if (sec_tick !== 1'b0) $display("FAIL reset_tick got %b want 0", sec_tick); else passes++;
      reset_n = 1'b1;
      step(1);
      interval_sel = 4'd15;
      step(1);
      checks++; if (tm !== 16'h8000) $display("FAIL off_sel15 got %h want 8000", tm); else passes++;
      interval_sel = 4'd0;
      step(1);
      checks++; if (tm !== 16'h0500) $display("FAIL off_sel0 got %h want 0500", tm); else passes++;
   endtask

   task automatic test_countdown();
      mode = 2'b01;
      step(1);
      checks++; if (tm !== 16'h0500) $display("FAIL run_start got %h want 0500", tm); else passes++;
      step(3);
      checks++; if (sec_tick !== 1'b1) $display("FAIL first_tick got %b want 1", sec_tick); else passes++;
      step(1);
      checks++; if (tm !== 16'h0459) $display("FAIL first_dec got %h want 0459", tm); else passes++;
      mode = 2'b11;
      step(118);
      checks++; if (tm !== 16'h0400) $display("FAIL test_0400 got %h want 0400", tm); else passes++;
      step(2);
      checks++; if (tm !== 16'h0359) $display("FAIL min_borrow got %h want 0359", tm); else passes++;
      step(476);
      checks++; if (tm !== 16'h0001 || alert !== 1'b0) $display("FAIL at_0001 got %h/%b want 0001/0", tm, alert); else passes++;
      step(2);
      checks++; if (tm !== 16'h0000 || alert !== 1'b1) $display("FAIL at_0000 got %h/%b want 0000/1", tm, alert); else passes++;
      step(3);
      checks++; if (tm !== 16'h0000 || alert !== 1'b1 || sec_tick !== 1'b0) $display("FAIL alert_hold got %h/%b/%b want 0000/1/0", tm, alert, sec_tick); else passes++;
   endtask

   task automatic test_priority();
      ack = 1'b1;
      step(2);
      mode = 2'b00;
      step(1);
      ack = 1'b0;
      checks++; if (alert !== 1'b0 || dr !== 8'h00 || tm !== 16'h0500) $display("FAIL off_beats_ack got %b/%h/%h want 0/00/0500", alert, dr, tm); else passes++;
      step(2);
      mode = 2'b01;
      step(1);
      ack = 1'b1;
      step(4);
      ack = 1'b0;
      step(2);
      checks++; if (dr !== 8'h00 || alert !== 1'b0) $display("FAIL ack_in_run got %h/%b want 00/0", dr, alert); else passes++;
   endtask

   task automatic test_pause();
      int bad;
      mode = 2'b00;
      step(1);
      mode = 2'b01;
      step(1);
      step(2);
      checks++; if (tm !== 16'h0500 || sec_tick !== 1'b0) $display("FAIL pre_pause got %h/%b want 0500/0", tm, sec_tick); else passes++;
      mode = 2'b10;
      step(1);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         step(1);
         if (tm !== 16'h0500 || sec_tick !== 1'b0) bad++;
      end
      checks++; if (bad != 0) $display("FAIL pause_frozen got %0d bad cycles want 0", bad); else passes++;
      mode = 2'b01;
      step(1);
      checks++; if (sec_tick !== 1'b1 || tm !== 16'h0500) $display("FAIL resume_held got %b/%h want 1/0500", sec_tick, tm); else passes++;
      step(1);
      checks++; if (tm !== 16'h0459) $display("FAIL resume_dec got %h want 0459", tm); else passes++;
      mode = 2'b11;
      step(1);
      checks++; if (sec_tick !== 1'b1) $display("FAIL test_rate_tick got %b want 1", sec_tick); else passes++;
      step(1);
      checks++; if (tm !== 16'h0458) $display("FAIL test_rate_1 got %h want 0458", tm); else passes++;
      step(2);
      checks++; if (tm !== 16'h0457) $display("FAIL test_rate_2 got %h want 0457", tm); else passes++;
      mode = 2'b01;
      step(2);
      checks++; if (sec_tick !== 1'b0) $display("FAIL pre_switch got %b want 0", sec_tick); else passes++;
      mode = 2'b11;
      #1;
      checks++; if (sec_tick !== 1'b1) $display("FAIL switch_wrap got %b want 1", sec_tick); else passes++;
      step(1);
      checks++; if (tm !== 16'h0456) $display("FAIL switch_dec got %h want 0456", tm); else passes++;
   endtask

   task automatic test_saturate();
      bit ok;
      for (int i = 1; i <= 100; i++) begin
         wait_alert(800, ok);
         checks++; if (!ok) $display("FAIL alert_timeout iter %0d got alert %b want 1", i, alert); else passes++;
         ack = 1'b1;
         step(2);
         if (i == 1) begin
            checks++; if (alert !== 1'b1) $display("FAIL ack_early got %b want 1", alert); else passes++;
         end
         step(1);
         if (i == 1) begin
            checks++; if (alert !== 1'b0 || dr !== 8'h01 || tm !== 16'h0500) $display("FAIL ack_exit got %b/%h/%h want 0/01/0500", alert, dr, tm); else passes++;
         end
         ack = 1'b0;
         step(2);
         if (i == 10) begin
            checks++; if (dr !== 8'h10) $display("FAIL drinks_10 got %h want 10", dr); else passes++;
         end
         if (i == 99) begin
            checks++; if (dr !== 8'h99) $display("FAIL drinks_99 got %h want 99", dr); else passes++;
         end
         if (i == 100) begin
            checks++; if (dr !== 8'h99) $display("FAIL drinks_sat got %h want 99", dr); else passes++;
         end
      end
   endtask

   task automatic test_async_reset();
      interval_sel = 4'd3;
      step(1);
      checks++; if (tm !== 16'h0459) $display("FAIL no_reload_run got %h want 0459", tm); else passes++;
      #2;
      reset_n = 1'b0;
      #1;
      checks++; if (tm !== 16'h2000 || alert !== 1'b0 || dr !== 8'h00 || sec_tick !== 1'b0) $display("FAIL async_reset got %h/%b/%h/%b want 2000/0/00/0", tm, alert, dr, sec_tick); else passes++;
      step(2);
      reset_n = 1'b1;
      interval_sel = 4'd0;
      step(1);
   endtask

`ifdef REMINDER_SNOOZE_EN
   task automatic test_snooze();
      bit ok;
      interval_sel = 4'd1;
      mode = 2'b11;
      step(1);
      wait_alert(1400, ok);
      checks++; if (!ok) $display("FAIL snooze_alert1 got %b want 1", alert); else passes++;
      snooze = 1'b1;
      step(2);
      checks++; if (alert !== 1'b1) $display("FAIL snooze_early got %b want 1", alert); else passes++;
      step(1);
      checks++; if (alert !== 1'b0 || tm !== 16'h0500 || dr !== 8'h00) $display("FAIL snooze_exit got %b/%h/%h want 0/0500/00", alert, tm, dr); else passes++;
      snooze = 1'b0;
      step(2);
      wait_alert(800, ok);
      checks++; if (!ok) $display("FAIL snooze_alert2 got %b want 1", alert); else passes++;
      ack = 1'b1;
      snooze = 1'b1;
      step(3);
      checks++; if (alert !== 1'b0 || tm !== 16'h1000 || dr !== 8'h01) $display("FAIL ack_beats_snooze got %b/%h/%h want 0/1000/01", alert, tm, dr); else passes++;
      ack = 1'b0;
      snooze = 1'b0;
      step(2);
   endtask
`endif

   initial begin
      test_reset();
      test_countdown();
      test_priority();
      test_pause();
      test_saturate();
      test_async_reset();
`ifdef REMINDER_SNOOZE_EN
      test_snooze();
`endif
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
